// File: rtl/dp_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dp_ram_port_arbiter
// Shares the two ports (A, B) of a dual-port RAM among NUM_REQ requesters.
// Up to two requests are granted per cycle in round-robin order. A request
// whose address matches the port-A address is held off for that cycle, so the
// two ports never touch the same location together. Granted commands are
// registered onto the RAM ports. Read responses return to the issuing
// requester two cycles after the handshake edge.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   req/we/addr/wdata         per-requester command (packed, requester i at slice i)
//   gnt                       combinational grant, transfer when req[i] && gnt[i]
//   rvalid/rdata              per-requester read response (1-cycle pulse / held data)
//   ram_addr_x, ram_we_x      registered RAM port command (x = a, b)
//   ram_drv_en_x, ram_wdat_x  registered tri-state enable and value for dbus_x
//   ram_dout_x                RAM read data for port x
// -----------------------------------------------------------------------------
module dp_ram_port_arbiter #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_BITS = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] addr,
    input  logic [NUM_REQ*DATA_BITS-1:0] wdata,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           rvalid,
    output logic [NUM_REQ*DATA_BITS-1:0] rdata,
    output logic [ADDR_SIZE-1:0]         ram_addr_a,
    output logic                         ram_we_a,
    output logic                         ram_drv_en_a,
    output logic [DATA_BITS-1:0]         ram_wdat_a,
    input  logic [DATA_BITS-1:0]         ram_dout_a,
    output logic [ADDR_SIZE-1:0]         ram_addr_b,
    output logic                         ram_we_b,
    output logic                         ram_drv_en_b,
    output logic [DATA_BITS-1:0]         ram_wdat_b,
    input  logic [DATA_BITS-1:0]         ram_dout_b
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // (base + offs) modulo NUM_REQ; offs never exceeds NUM_REQ-1
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int offs);
        int sum_v;
        sum_v = int'(base) + offs;
        return IDX_W'((sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v);
    endfunction

    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     scan_idx_s [NUM_REQ];
    logic                 sel_a_s;
    logic                 sel_b_s;
    logic [IDX_W-1:0]     idx_a_s;
    logic [IDX_W-1:0]     idx_b_s;
    logic [ADDR_SIZE-1:0] addr_sel_a_s;
    logic [ADDR_SIZE-1:0] addr_sel_b_s;
    logic [IDX_W-1:0]     last_idx_s;
    logic [IDX_W-1:0]     ptr_nxt_s;

    logic                 tag_a1_vld_r;
    logic [IDX_W-1:0]     tag_a1_id_r;
    logic                 tag_a2_vld_r;
    logic [IDX_W-1:0]     tag_a2_id_r;
    logic                 tag_b1_vld_r;
    logic [IDX_W-1:0]     tag_b1_id_r;
    logic                 tag_b2_vld_r;
    logic [IDX_W-1:0]     tag_b2_id_r;
    logic [NUM_REQ-1:0]   rsp_mask_s;

    // Requester index visited at each scan position, starting at the pointer
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_s[k] = wrap_idx(ptr_r, k);
        end
    end

    // Round-robin scan: first requester takes port A, the next one with a
    // different address takes port B; same-address requesters wait a cycle
    always_comb begin
        sel_a_s      = 1'b0;
        sel_b_s      = 1'b0;
        idx_a_s      = '0;
        idx_b_s      = '0;
        addr_sel_a_s = '0;
        addr_sel_b_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[scan_idx_s[k]] && !rst) begin
                if (!sel_a_s) begin
                    sel_a_s      = 1'b1;
                    idx_a_s      = scan_idx_s[k];
                    addr_sel_a_s = addr[int'(scan_idx_s[k]) * ADDR_SIZE +: ADDR_SIZE];
                end else if (!sel_b_s &&
                             (addr[int'(scan_idx_s[k]) * ADDR_SIZE +: ADDR_SIZE] != addr_sel_a_s)) begin
                    sel_b_s      = 1'b1;
                    idx_b_s      = scan_idx_s[k];
                    addr_sel_b_s = addr[int'(scan_idx_s[k]) * ADDR_SIZE +: ADDR_SIZE];
                end else begin
                    // already two winners, or colliding with port A: skipped
                    sel_b_s = sel_b_s;
                end
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Grant vector and the pointer value following the last winner
    always_comb begin
        gnt        = (NUM_REQ'(sel_a_s) << idx_a_s) | (NUM_REQ'(sel_b_s) << idx_b_s);
        last_idx_s = sel_b_s ? idx_b_s : idx_a_s;
        ptr_nxt_s  = wrap_idx(last_idx_s, 1);
    end

    // Round-robin pointer, advanced only on cycles with a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (sel_a_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Port A command register; an idle port keeps its address
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_a   <= '0;
            ram_we_a     <= 1'b0;
            ram_drv_en_a <= 1'b0;
            ram_wdat_a   <= '0;
        end else if (sel_a_s) begin
            ram_addr_a   <= addr_sel_a_s;
            ram_we_a     <= we[idx_a_s];
            ram_drv_en_a <= we[idx_a_s];
            ram_wdat_a   <= wdata[int'(idx_a_s) * DATA_BITS +: DATA_BITS];
        end else begin
            ram_we_a     <= 1'b0;
            ram_drv_en_a <= 1'b0;
        end
    end

    // Port B command register; an idle port keeps its address
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_b   <= '0;
            ram_we_b     <= 1'b0;
            ram_drv_en_b <= 1'b0;
            ram_wdat_b   <= '0;
        end else if (sel_b_s) begin
            ram_addr_b   <= addr_sel_b_s;
            ram_we_b     <= we[idx_b_s];
            ram_drv_en_b <= we[idx_b_s];
            ram_wdat_b   <= wdata[int'(idx_b_s) * DATA_BITS +: DATA_BITS];
        end else begin
            ram_we_b     <= 1'b0;
            ram_drv_en_b <= 1'b0;
        end
    end

    // Two-stage read tags: stage 1 while the RAM reads, stage 2 while dout is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_a1_vld_r <= 1'b0;
            tag_a1_id_r  <= '0;
            tag_a2_vld_r <= 1'b0;
            tag_a2_id_r  <= '0;
            tag_b1_vld_r <= 1'b0;
            tag_b1_id_r  <= '0;
            tag_b2_vld_r <= 1'b0;
            tag_b2_id_r  <= '0;
        end else begin
            tag_a1_vld_r <= sel_a_s && !we[idx_a_s];
            tag_a1_id_r  <= idx_a_s;
            tag_a2_vld_r <= tag_a1_vld_r;
            tag_a2_id_r  <= tag_a1_id_r;
            tag_b1_vld_r <= sel_b_s && !we[idx_b_s];
            tag_b1_id_r  <= idx_b_s;
            tag_b2_vld_r <= tag_b1_vld_r;
            tag_b2_id_r  <= tag_b1_id_r;
        end
    end

    // Requesters receiving read data this cycle (both ports may complete at once)
    always_comb begin
        rsp_mask_s = (NUM_REQ'(tag_a2_vld_r) << tag_a2_id_r) |
                     (NUM_REQ'(tag_b2_vld_r) << tag_b2_id_r);
    end

    // Response registers; rdata slices hold between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rsp_mask_s;
            if (tag_a2_vld_r) begin
                rdata[int'(tag_a2_id_r) * DATA_BITS +: DATA_BITS] <= ram_dout_a;
            end
            if (tag_b2_vld_r) begin
                rdata[int'(tag_b2_id_r) * DATA_BITS +: DATA_BITS] <= ram_dout_b;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dp_ram_port_arbiter. Includes a behavioural dual-port RAM
// driven by the arbiter's port outputs, a reference model (memory image,
// rotating-order arbitration, response scoreboard keyed by due edge),
// a vector table, hand-written corner sequences and a randomized phase.
// -----------------------------------------------------------------------------
module tb_dp_ram_port_arbiter;

    localparam int A = 6;
    localparam int D = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, we;
    logic [N*A-1:0] addr;
    logic [N*D-1:0] wdata;
    logic [N-1:0]   gnt, rvalid;
    logic [N*D-1:0] rdata;
    logic [A-1:0]   ram_addr_a, ram_addr_b;
    logic           ram_we_a, ram_we_b, ram_drv_en_a, ram_drv_en_b;
    logic [D-1:0]   ram_wdat_a, ram_wdat_b, ram_dout_a, ram_dout_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_cnt     = 0;
    int rv3_count    = 0;

    dp_ram_port_arbiter #(.ADDR_SIZE(A), .DATA_BITS(D), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_drv_en_a(ram_drv_en_a),
        .ram_wdat_a(ram_wdat_a), .ram_dout_a(ram_dout_a),
        .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_drv_en_b(ram_drv_en_b),
        .ram_wdat_b(ram_wdat_b), .ram_dout_b(ram_dout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Dual-port RAM: a write needs both we and an enabled bus driver
    logic [D-1:0] ram_mem [2**A];
    always @(posedge clk) begin
        if (ram_we_a && ram_drv_en_a) ram_mem[ram_addr_a] <= ram_wdat_a;
        else                          ram_dout_a <= ram_mem[ram_addr_a];
        if (ram_we_b && ram_drv_en_b) ram_mem[ram_addr_b] <= ram_wdat_b;
        else                          ram_dout_b <= ram_mem[ram_addr_b];
    end

    // ---------------- reference model ----------------
    logic [D-1:0] m_mem [2**A];
    int           m_ptr = 0;
    typedef struct { int due; int id; logic [D-1:0] data; } rsp_t;
    rsp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Visit requesters in order p, p+1, ... mod N; first wins A, next with another address wins B
    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input logic [N*A-1:0] ad,
                                               input int p, output int np);
        int first, second, i;
        logic [N-1:0] g;
        first = -1; second = -1; g = '0; np = p;
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (r[i]) begin
                if (first < 0) first = i;
                else if (second < 0 && ad[i*A +: A] != ad[first*A +: A]) second = i;
            end
        end
        if (first >= 0)  begin g[first]  = 1'b1; np = (first + 1) % N;  end
        if (second >= 0) begin g[second] = 1'b1; np = (second + 1) % N; end
        return g;
    endfunction

    // One clock cycle: drive, check gnt, update model, check responses after the edge
    task automatic run_cycle(input logic r_rst, input logic [N-1:0] r_req, input logic [N-1:0] r_we,
                             input logic [N*A-1:0] r_addr, input logic [N*D-1:0] r_wdata,
                             output logic [N-1:0] exp_g, output logic [N-1:0] obs_g);
        int np;
        logic [N-1:0] exp_rv;
        logic [D-1:0] exp_rd [N];
        rst = r_rst; req = r_req; we = r_we; addr = r_addr; wdata = r_wdata;
        @(negedge clk);
        if (r_rst) begin exp_g = '0; np = 0; end
        else exp_g = model_gnt(r_req, r_addr, m_ptr, np);
        obs_g = gnt;
        check("gnt", gnt, exp_g);
        if (r_rst) sb.delete();
        else begin
            for (int i = 0; i < N; i++) begin
                if (exp_g[i]) begin
                    if (r_we[i]) m_mem[r_addr[i*A +: A]] = r_wdata[i*D +: D];
                    else sb.push_back('{due: edge_cnt + 3, id: i, data: m_mem[r_addr[i*A +: A]]});
                end
            end
        end
        m_ptr = np;
        @(posedge clk);
        #1;
        exp_rv = '0;
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
        for (int q = sb.size() - 1; q >= 0; q--) begin
            if (sb[q].due == edge_cnt) begin
                exp_rv[sb[q].id] = 1'b1;
                exp_rd[sb[q].id] = sb[q].data;
                sb.delete(q);
            end
        end
        check("rvalid", rvalid, exp_rv);
        for (int i = 0; i < N; i++)
            if (exp_rv[i]) check($sformatf("rdata[%0d]", i), rdata[i*D +: D], exp_rd[i]);
        if (rvalid[3]) rv3_count++;
    endtask

    task automatic idle(input int n);
        logic [N-1:0] g, o;
        for (int k = 0; k < n; k++) run_cycle(1'b0, '0, '0, '0, '0, g, o);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   we;
        logic [N*A-1:0] addr;
        logic [N*D-1:0] wdata;
        logic [N-1:0]   exp_gnt;
    } vec_t;
    vec_t vecs [10];

    logic [N-1:0]   g, o;
    logic [N-1:0]   p_req, p_we;
    logic [N*A-1:0] p_addr;
    logic [N*D-1:0] p_wd;

    initial begin
        // collision, then held requester; pointer realign; four-way round-robin
        vecs[0] = '{4'b0011, 4'b0001, {6'h00, 6'h00, 6'h03, 6'h03}, {8'h00, 8'h00, 8'h00, 8'h55}, 4'b0001};
        vecs[1] = '{4'b0010, 4'b0000, {6'h00, 6'h00, 6'h03, 6'h00}, 32'h0, 4'b0010};
        vecs[2] = '{4'b0000, 4'b0000, 24'h0, 32'h0, 4'b0000};
        vecs[3] = '{4'b0000, 4'b0000, 24'h0, 32'h0, 4'b0000};
        vecs[4] = '{4'b1000, 4'b1000, {6'h14, 6'h00, 6'h00, 6'h00}, {8'h66, 8'h00, 8'h00, 8'h00}, 4'b1000};
        vecs[5] = '{4'b1111, 4'b1111, {6'h13, 6'h12, 6'h11, 6'h10}, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, 4'b0011};
        vecs[6] = '{4'b1111, 4'b1111, {6'h13, 6'h12, 6'h11, 6'h10}, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, 4'b1100};
        vecs[7] = '{4'b1111, 4'b1111, {6'h13, 6'h12, 6'h11, 6'h10}, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, 4'b0011};
        vecs[8] = '{4'b1111, 4'b1111, {6'h13, 6'h12, 6'h11, 6'h10}, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, 4'b1100};
        vecs[9] = '{4'b0000, 4'b0000, 24'h0, 32'h0, 4'b0000};

        rst = 1'b1; req = 4'hF; we = '0; addr = '0; wdata = '0;
        @(posedge clk);
        #1;

        // 1: reset held two cycles with every request raised
        for (int k = 0; k < 2; k++) begin
            run_cycle(1'b1, 4'hF, 4'h0, 24'h0, 32'h0, g, o);
            check("rst_we_a", ram_we_a, 1'b0);
            check("rst_we_b", ram_we_b, 1'b0);
            check("rst_drv_a", ram_drv_en_a, 1'b0);
            check("rst_drv_b", ram_drv_en_b, 1'b0);
            check("rst_rdata", rdata, 32'h0);
        end

        // 2: dual write, then dual read of the same locations
        run_cycle(1'b0, 4'b0011, 4'b0011, {6'h00, 6'h00, 6'h02, 6'h01}, {8'h00, 8'h00, 8'h44, 8'h33}, g, o);
        check("w_gnt", o, 4'b0011);
        check("w_we_a", ram_we_a, 1'b1);
        check("w_drv_a", ram_drv_en_a, 1'b1);
        check("w_addr_a", ram_addr_a, 6'h01);
        check("w_wdat_a", ram_wdat_a, 8'h33);
        check("w_we_b", ram_we_b, 1'b1);
        check("w_drv_b", ram_drv_en_b, 1'b1);
        check("w_addr_b", ram_addr_b, 6'h02);
        check("w_wdat_b", ram_wdat_b, 8'h44);
        run_cycle(1'b0, 4'b1100, 4'b0000, {6'h02, 6'h01, 6'h00, 6'h00}, 32'h0, g, o);
        check("r_gnt", o, 4'b1100);
        check("r_we_a", ram_we_a, 1'b0);
        check("r_drv_a", ram_drv_en_a, 1'b0);
        check("r_addr_a", ram_addr_a, 6'h01);
        check("r_addr_b", ram_addr_b, 6'h02);
        idle(3);
        check("rdata2_hold", rdata[2*D +: D], 8'h33);
        check("rdata3_hold", rdata[3*D +: D], 8'h44);

        // 3 and 4: table of single-cycle vectors
        for (int v = 0; v < 10; v++) begin
            run_cycle(1'b0, vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata, g, o);
            check($sformatf("vec%0d_gnt", v), o, vecs[v].exp_gnt);
        end
        idle(2);

        // 5: reset one cycle after a read is granted; in-flight read is dropped
        run_cycle(1'b0, 4'b0100, 4'b0000, {6'h00, 6'h01, 6'h00, 6'h00}, 32'h0, g, o);
        check("mr_gnt", o, 4'b0100);
        run_cycle(1'b1, 4'b0000, 4'b0000, 24'h0, 32'h0, g, o);
        idle(3);
        run_cycle(1'b0, 4'b1111, 4'b0000, {6'h11, 6'h10, 6'h02, 6'h01}, 32'h0, g, o);
        check("post_rst_gnt", o, 4'b0011);
        run_cycle(1'b0, 4'b1100, 4'b0000, {6'h11, 6'h10, 6'h00, 6'h00}, 32'h0, g, o);
        check("post_rst_gnt2", o, 4'b1100);
        idle(3);
        check("post_rst_rdata0", rdata[0 +: D], 8'h33);

        // 6: fill the whole RAM, then one requester reads it back-to-back
        for (int a = 0; a < 2**A; a++)
            run_cycle(1'b0, 4'b0001, 4'b0001, {18'h0, A'(a)}, {24'h0, D'($urandom)}, g, o);
        rv3_count = 0;
        for (int a = 0; a < 2**A; a++) begin
            run_cycle(1'b0, 4'b1000, 4'b0000, {A'(a), 18'h0}, 32'h0, g, o);
            if (a == 0 || a == 2**A - 1) check($sformatf("seq_gnt%0d", a), o, 4'b1000);
        end
        idle(3);
        check("seq_rvalid3_pulses", rv3_count, 64);

        // randomized traffic: requests held until granted, narrow address range, rare resets
        p_req = '0; p_we = '0; p_addr = '0; p_wd = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_req[i] && $urandom_range(0, 2) != 0) begin
                    p_req[i]        = 1'b1;
                    p_we[i]         = 1'($urandom_range(0, 1));
                    p_addr[i*A +: A] = A'($urandom_range(0, 7));
                    p_wd[i*D +: D]   = D'($urandom);
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                run_cycle(1'b1, p_req, p_we, p_addr, p_wd, g, o);
            end else begin
                run_cycle(1'b0, p_req, p_we, p_addr, p_wd, g, o);
                p_req = p_req & ~g;
            end
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
